signal_conflict_monitor: RTL and testbench
==========================================

Name: signal_conflict_monitor

Overview:
- Safety stage directly downstream of the two-road light controller FSM.
- Samples the six raw lamp commands and forwards them, registered, to the lamp drivers while they are legal.
- On any illegal combination, illegal sequence or stuck configuration: blocks the bad command, latches a fault code and drives fail-safe flashing red on both roads until software clears it.

Parameters:
- START_CYCLES, 4: cycles of steady all-red after reset or fault clear before monitoring begins (>=1).
- STUCK_MAX, 16: maximum consecutive cycles one lamp configuration may persist (>=1).
- FLASH_DIV, 4: flash half-period in cycles (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ns_g_i, ns_y_i, ns_r_i  in  1 each  NS lamp commands from controller.
- ew_g_i, ew_y_i, ew_r_i  in  1 each  EW lamp commands from controller.
- clr_fault  in  1  single-cycle fault clear request.
- ns_g_o, ns_y_o, ns_r_o  out  1 each  NS lamp drive, registered.
- ew_g_o, ew_y_o, ew_r_o  out  1 each  EW lamp drive, registered.
- fault  out  1  high while in FAULT.
- fault_code  out  3  latched cause: 0 none, 1 non-one-hot road, 2 conflict, 3 illegal sequence, 4 stuck.
- trip_cnt  out  8  saturating count of fault entries.

Behaviour:
- One clock; reset is synchronous and active-low. rst_n low at a rising edge dominates all other inputs.
- Reset values:
  - ns_r_o = ew_r_o = 1; all other lamp outputs 0.
  - fault = 0, fault_code = 0, trip_cnt = 0.
  - State SAFE_START, start counter 0, stuck counter 0, previous-sample-valid flag 0.
- States: SAFE_START, MONITOR, FAULT.
- SAFE_START:
  - Outputs steady all-red; inputs ignored.
  - After START_CYCLES edges in this state, go to MONITOR and clear the previous-sample-valid flag.
- MONITOR: each edge, evaluate the current inputs. Checks in priority order:
  - Code 1: either road's {g,y,r} is not exactly one-hot.
  - Code 2: neither ns_r_i nor ew_r_i is set.
  - Code 3 (only when previous-sample-valid = 1): a road changed lamp in a way other than G->Y, Y->R or R->G.
  - Code 4: stuck counter has reached STUCK_MAX and the inputs equal the previous sample. This trips on the (STUCK_MAX+1)th consecutive identical sample.
- MONITOR, no fault:
  - Lamp outputs take the input values at this edge (1-cycle latency).
  - The previous sample is stored and previous-sample-valid is set to 1.
  - Stuck counter: 0 if the inputs differ from the previous sample or previous-sample-valid = 0; otherwise +1.
- MONITOR, fault detected at an edge:
  - At that same edge: go to FAULT, fault = 1, latch fault_code, trip_cnt +1 (saturates at 255).
  - Lamp outputs load the fail-safe pattern. An illegal input never reaches the outputs.
- FAULT:
  - ns_r_o = ew_r_o = flash; all greens and yellows 0.
  - flash = 1 for the first FLASH_DIV cycles after entry, then toggles every FLASH_DIV cycles.
  - Inputs ignored; fault_code held.
- clr_fault:
  - Sampled high in FAULT: next state SAFE_START, fault = 0, fault_code = 0, outputs steady all-red, start counter 0. trip_cnt is retained.
  - Ignored in SAFE_START and MONITOR.
  - If the fault condition persists after SAFE_START, MONITOR re-trips on its first evaluated cycle.
- Simultaneous conditions: highest-priority (lowest nonzero) code is latched.
- Reset asserted in any state, including mid-flash: returns to reset values at that edge.
- trip_cnt is cleared only by reset.

Test Plan:
- Reset then legal four-phase cycle, one phase per clock:
  - Outputs all-red for 4 cycles, then mirror the inputs with 1-cycle delay.
  - fault stays 0 and trip_cnt stays 0 over 100 cycles.
- In MONITOR drive ns_g_i = 1 and ew_g_i = 1 with both reds 0:
  - At that edge fault = 1, fault_code = 2, trip_cnt = 1.
  - No output green ever shows both roads; reds flash 4 on / 4 off.
- In MONITOR drive NS directly G->R:
  - fault_code = 3.
  - Drive ns_g_i = ns_y_i = 1 on a later run: fault_code = 1 (priority over 2 and 3).
- Hold one legal configuration constant for 17 samples:
  - No fault through the 16th sample.
  - fault_code = 4 at the 17th.
  - Same test with a change at sample 16: no fault.
- In FAULT pulse clr_fault with legal inputs:
  - 4 all-red cycles, then MONITOR resumes, fault = 0, fault_code = 0, trip_cnt held at 1.
  - Repeat the pulse with conflicting inputs: re-trip after 4 cycles, trip_cnt = 2.
- Force 256 trips: trip_cnt saturates at 255. Assert rst_n = 0 mid-flash: next edge gives all-red steady, fault = 0, trip_cnt = 0.

Source files
------------

// File: rtl/signal_conflict_monitor.sv
// Safety stage between the two-road light controller and the lamp drivers.
// Forwards legal lamp commands registered and latches a flashing-red fault state otherwise.
module signal_conflict_monitor #(
    parameter int START_CYCLES = 4,
    parameter int STUCK_MAX    = 16,
    parameter int FLASH_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_g_i,
    input  logic       ns_y_i,
    input  logic       ns_r_i,
    input  logic       ew_g_i,
    input  logic       ew_y_i,
    input  logic       ew_r_i,
    input  logic       clr_fault,
    output logic       ns_g_o,
    output logic       ns_y_o,
    output logic       ns_r_o,
    output logic       ew_g_o,
    output logic       ew_y_o,
    output logic       ew_r_o,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] trip_cnt
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_MON   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam int SW = $clog2(START_CYCLES + 1);
    localparam int KW = $clog2(STUCK_MAX + 1);
    localparam int FW = $clog2(FLASH_DIV + 1);

    // Lamp vectors are packed {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}.
    localparam logic [5:0] ALL_RED = 6'b001_001;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] start_q, start_d;
    logic [KW-1:0] stuck_q, stuck_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_q, flash_d;
    logic          pv_q, pv_d;
    logic [5:0]    prev_q, prev_d;
    logic [5:0]    lamp_q, lamp_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;
    logic [7:0]    trip_q, trip_d;

    logic [5:0]    cur;
    logic          same;
    logic [2:0]    det;

    function automatic logic is_onehot3(input logic [2:0] x);
        return (x == 3'b100) || (x == 3'b010) || (x == 3'b001);
    endfunction

    // Holding a lamp is legal; the only legal changes are G->Y, Y->R and R->G.
    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
        return (p == c) ||
               (p == 3'b100 && c == 3'b010) ||
               (p == 3'b010 && c == 3'b001) ||
               (p == 3'b001 && c == 3'b100);
    endfunction

    assign cur  = {ns_g_i, ns_y_i, ns_r_i, ew_g_i, ew_y_i, ew_r_i};
    assign same = pv_q && (cur == prev_q);

    always_comb begin
        det = 3'd0;
        if (!is_onehot3(cur[5:3]) || !is_onehot3(cur[2:0])) begin
            det = 3'd1;
        end else if (!cur[3] && !cur[0]) begin
            det = 3'd2;
        end else if (pv_q && (!legal_step(prev_q[5:3], cur[5:3]) ||
                              !legal_step(prev_q[2:0], cur[2:0]))) begin
            det = 3'd3;
        end else if (same && (stuck_q >= KW'(STUCK_MAX - 1))) begin
            // The count reaching STUCK_MAX on this sample means STUCK_MAX+1 identical samples.
            det = 3'd4;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        stuck_d     = stuck_q;
        flash_cnt_d = flash_cnt_q;
        flash_d     = flash_q;
        pv_d        = pv_q;
        prev_d      = prev_q;
        lamp_d      = lamp_q;
        fault_d     = fault_q;
        code_d      = code_q;
        trip_d      = trip_q;
        case (state_q)
            S_START: begin
                lamp_d = ALL_RED;
                if (start_q == SW'(START_CYCLES - 1)) begin
                    state_d = S_MON;
                    start_d = '0;
                    stuck_d = '0;
                    pv_d    = 1'b0;
                end else begin
                    start_d = start_q + 1'b1;
                end
            end
            S_MON: begin
                if (det != 3'd0) begin
                    state_d     = S_FAULT;
                    fault_d     = 1'b1;
                    code_d      = det;
                    trip_d      = (trip_q == 8'hFF) ? trip_q : trip_q + 8'd1;
                    lamp_d      = ALL_RED;
                    flash_d     = 1'b1;
                    flash_cnt_d = '0;
                end else begin
                    lamp_d  = cur;
                    prev_d  = cur;
                    pv_d    = 1'b1;
                    stuck_d = same ? stuck_q + 1'b1 : '0;
                end
            end
            S_FAULT: begin
                if (clr_fault) begin
                    state_d = S_START;
                    fault_d = 1'b0;
                    code_d  = 3'd0;
                    lamp_d  = ALL_RED;
                    start_d = '0;
                end else if (flash_cnt_q == FW'(FLASH_DIV - 1)) begin
                    flash_cnt_d = '0;
                    flash_d     = ~flash_q;
                    lamp_d      = {2'b00, ~flash_q, 2'b00, ~flash_q};
                end else begin
                    flash_cnt_d = flash_cnt_q + 1'b1;
                    lamp_d      = {2'b00, flash_q, 2'b00, flash_q};
                end
            end
            default: begin
                state_d = S_START;
                start_d = '0;
                lamp_d  = ALL_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_START;
            start_q     <= '0;
            stuck_q     <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b1;
            pv_q        <= 1'b0;
            prev_q      <= ALL_RED;
            lamp_q      <= ALL_RED;
            fault_q     <= 1'b0;
            code_q      <= 3'd0;
            trip_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            stuck_q     <= stuck_d;
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
            pv_q        <= pv_d;
            prev_q      <= prev_d;
            lamp_q      <= lamp_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            trip_q      <= trip_d;
        end
    end

    assign {ns_g_o, ns_y_o, ns_r_o, ew_g_o, ew_y_o, ew_r_o} = lamp_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign trip_cnt   = trip_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Scoreboard bench for signal_conflict_monitor: stimulus pushes expected
// outputs per edge, a monitor pops and compares after each rising edge.
module tb_signal_conflict_monitor;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;
    localparam logic [5:0] RED = 6'b001_001;
    localparam int FLASH = 4;

    typedef struct {
        logic [5:0] lamps;
        logic       f;
        logic [2:0] c;
        logic [7:0] t;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] in_v = RED;
    logic       clr = 1'b0;
    logic       ns_g_o, ns_y_o, ns_r_o, ew_g_o, ew_y_o, ew_r_o;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] trip_cnt;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   trips = 0;
    int   fk = 0;
    logic [2:0] ecode = 3'd0;
    logic [5:0] ph [4];

    always #5 clk = ~clk;

    signal_conflict_monitor #(.START_CYCLES(4), .STUCK_MAX(16), .FLASH_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ns_g_i(in_v[5]), .ns_y_i(in_v[4]), .ns_r_i(in_v[3]),
        .ew_g_i(in_v[2]), .ew_y_i(in_v[1]), .ew_r_i(in_v[0]),
        .clr_fault(clr),
        .ns_g_o(ns_g_o), .ns_y_o(ns_y_o), .ns_r_o(ns_r_o),
        .ew_g_o(ew_g_o), .ew_y_o(ew_y_o), .ew_r_o(ew_r_o),
        .fault(fault), .fault_code(fault_code), .trip_cnt(trip_cnt)
    );

    task automatic step(input logic rn, input logic [5:0] v, input logic c,
                        input logic [5:0] el, input logic ef, input logic [2:0] ec,
                        input int et, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        in_v  = v;
        clr   = c;
        e.lamps = el; e.f = ef; e.c = ec; e.t = 8'(et); e.nm = nm;
        q.push_back(e);
    endtask

    task automatic mon(input logic [5:0] v);
        step(1'b1, v, 1'b0, v, 1'b0, 3'd0, trips, "monitor");
    endtask

    task automatic trip(input logic [5:0] v, input logic [2:0] code, input string nm);
        if (trips < 255) trips++;
        ecode = code;
        fk = 0;
        step(1'b1, v, 1'b0, RED, 1'b1, code, trips, nm);
    endtask

    task automatic fault_hold(input int n, input logic [5:0] v);
        for (int i = 0; i < n; i++) begin
            fk++;
            step(1'b1, v, 1'b0, (((fk / FLASH) % 2) == 0) ? RED : 6'b0, 1'b1, ecode, trips, "flash");
        end
    endtask

    task automatic clear(input logic [5:0] v);
        step(1'b1, v, 1'b1, RED, 1'b0, 3'd0, trips, "clear");
        for (int i = 0; i < 4; i++)
            step(1'b1, v, 1'b0, RED, 1'b0, 3'd0, trips, "restart_red");
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_chk++;
                if ({ns_g_o, ns_y_o, ns_r_o, ew_g_o, ew_y_o, ew_r_o} === e.lamps &&
                    fault === e.f && fault_code === e.c && trip_cnt === e.t) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got lamps=%b fault=%b code=%0d trip=%0d, expected lamps=%b fault=%b code=%0d trip=%0d",
                             e.nm, {ns_g_o, ns_y_o, ns_r_o, ew_g_o, ew_y_o, ew_r_o}, fault,
                             fault_code, trip_cnt, e.lamps, e.f, e.c, e.t);
                end
            end
        end
    end

    initial begin
        ph[0] = {G, R}; ph[1] = {Y, R}; ph[2] = {R, G}; ph[3] = {R, Y};

        step(1'b0, RED, 1'b0, RED, 1'b0, 3'd0, 0, "reset");
        for (int i = 0; i < 4; i++)
            step(1'b1, ph[i], 1'b0, RED, 1'b0, 3'd0, 0, "startup_red");
        for (int i = 0; i < 96; i++) mon(ph[i % 4]);

        // conflict: both greens, no red
        trip({G, G}, 3'd2, "conflict");
        fault_hold(16, {G, G});
        clear({G, R});
        mon({G, R}); mon({Y, R}); mon({R, G}); mon({R, Y}); mon({G, R});

        // NS jumps G->R
        trip({R, G}, 3'd3, "illegal_seq");
        fault_hold(6, {R, G});

        // clear with conflicting inputs re-trips after the start window
        clear({G, G});
        trip({G, G}, 3'd2, "retrip");
        fault_hold(3, {G, G});

        // non-one-hot wins over conflict and sequence
        clear({G, R});
        mon({G, R});
        trip({3'b110, G}, 3'd1, "non_onehot");
        fault_hold(2, {3'b110, G});

        // stuck: 17th identical sample trips
        clear({G, R});
        for (int i = 0; i < 16; i++) mon({G, R});
        trip({G, R}, 3'd4, "stuck");
        fault_hold(2, {G, R});

        // change at sample 16 restarts the run
        clear({G, R});
        for (int i = 0; i < 15; i++) mon({G, R});
        for (int i = 0; i < 16; i++) mon({Y, R});
        mon({R, G});
        trip({G, G}, 3'd2, "conflict2");
        fault_hold(1, {G, G});

        // saturate trip counter
        for (int i = 0; i < 252; i++) begin
            clear({G, G});
            trip({G, G}, 3'd2, "sat_trip");
        end
        fault_hold(5, {G, G});

        // reset mid-flash (reds currently off)
        step(1'b0, {G, G}, 1'b0, RED, 1'b0, 3'd0, 0, "reset_mid_flash");
        trips = 0;
        for (int i = 0; i < 4; i++)
            step(1'b1, {G, G}, 1'b0, RED, 1'b0, 3'd0, 0, "post_reset_red");
        mon({G, R}); mon({Y, R}); mon({R, G});

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
